// File: rtl/jtdd_romarb_pkg.sv
// Shared types and widths for the jtdd video ROM arbiter.
// Build option JTDD_ROMARB_FIXPRIO_EN (used in jtdd_romarb.sv) selects
// fixed priority instead of round-robin.
package jtdd_romarb_pkg;

    // Requester identifiers; the numeric values double as round-robin order.
    typedef enum logic [1:0] {
        SLOT_CHAR = 2'd0,
        SLOT_SCR  = 2'd1,
        SLOT_OBJ  = 2'd2
    } slot_t;

    // SDRAM fetch sequencer states.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ACK  = 2'd1,
        WAIT_DATA = 2'd2
    } state_t;

    localparam int SDRAM_AW = 22;
    localparam int DATA_W   = 16;
    localparam int CHAR_AW  = 14;   // char word address = char_addr[14:1]
    localparam int SCR_AW   = 17;
    localparam int OBJ_AW   = 18;   // widest requester address

    // Slot that follows s in the CHAR -> SCR -> OBJ -> CHAR ring.
    function automatic slot_t next_slot(input slot_t s);
        case (s)
            SLOT_CHAR: return SLOT_SCR;
            SLOT_SCR:  return SLOT_OBJ;
            default:   return SLOT_CHAR;
        endcase
    endfunction

endpackage

// File: rtl/jtdd_romarb_slot.sv
// One-word cache for a single ROM requester: keeps the tag, data and valid
// bit of the last completed fetch and tells the arbiter whether the
// requester's current address is served (ok) or needs a fetch (pending).
module jtdd_romarb_slot
    import jtdd_romarb_pkg::*;
#(
    parameter int AW = 14
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr,
    input  logic [AW-1:0]     addr,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] data,
    output logic              ok,
    output logic              pending
);

    logic          valid;
    logic [AW-1:0] tag;

    // Cache registers: a download invalidates the word, a completed fetch
    // stores it against the address that was latched when it was issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            tag   <= '0;
            data  <= '0;
        end else if (clr) begin
            valid <= 1'b0;
        end else if (wr) begin
            valid <= 1'b1;
            tag   <= wr_addr;
            data  <= wr_data;
        end
    end

    // Hit test is combinational so ok falls in the same cycle the address moves.
    assign ok      = valid && (addr == tag);
    assign pending = !ok;

endmodule

// File: rtl/jtdd_romarb.sv
// Video ROM arbiter: shares the single SDRAM read port between the char,
// scroll and object fetchers, one outstanding request at a time, and keeps
// one cached word per fetcher.
// Build option: JTDD_ROMARB_FIXPRIO_EN selects fixed priority
// OBJ > CHAR > SCR; left undefined, the arbiter is round-robin.
//
// SDRAM handshake: sdram_req acts as valid and sdram_ack as ready. Once
// raised, sdram_req and sdram_addr hold steady until the cycle sdram_ack is
// seen, then sdram_req drops. data_rdy is a single-cycle strobe qualifying
// data_read and may coincide with sdram_ack. downloading masks sdram_req at
// once and abandons any fetch in flight.
module jtdd_romarb
    import jtdd_romarb_pkg::*;
#(
    parameter logic [SDRAM_AW-1:0] CHAR_OFFSET = 22'h00_0000,
    parameter logic [SDRAM_AW-1:0] SCR_OFFSET  = 22'h01_0000,
    parameter logic [SDRAM_AW-1:0] OBJ_OFFSET  = 22'h03_0000
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                downloading,
    input  logic [14:0]         char_addr,
    output logic [7:0]          char_data,
    output logic                char_ok,
    input  logic [16:0]         scr_addr,
    output logic [15:0]         scr_data,
    output logic                scr_ok,
    input  logic [17:0]         obj_addr,
    output logic [15:0]         obj_data,
    output logic                obj_ok,
    output logic                sdram_req,
    output logic [SDRAM_AW-1:0] sdram_addr,
    input  logic                sdram_ack,
    input  logic                data_rdy,
    input  logic [15:0]         data_read
);

    state_t              state;
    state_t              state_nxt;
    slot_t               sel_slot;
    slot_t               arb_slot;
    logic                start;
    logic                done;
    logic                req_q;
    logic [OBJ_AW-1:0]   lat_word;
    logic [OBJ_AW-1:0]   arb_word;
    logic [SDRAM_AW-1:0] arb_base;

    logic [DATA_W-1:0]   char_word;
    logic                char_pend;
    logic                scr_pend;
    logic                obj_pend;
    logic                char_wr;
    logic                scr_wr;
    logic                obj_wr;
    logic                any_pend;

    // ------------------------------------------------------------------
    // Per-requester caches
    // ------------------------------------------------------------------
    assign char_wr = done && (sel_slot == SLOT_CHAR);
    assign scr_wr  = done && (sel_slot == SLOT_SCR);
    assign obj_wr  = done && (sel_slot == SLOT_OBJ);

    jtdd_romarb_slot #(.AW(CHAR_AW)) u_char (
        .clk     (clk),
        .rst     (rst),
        .clr     (downloading),
        .wr      (char_wr),
        .addr    (char_addr[14:1]),
        .wr_addr (lat_word[CHAR_AW-1:0]),
        .wr_data (data_read),
        .data    (char_word),
        .ok      (char_ok),
        .pending (char_pend)
    );

    jtdd_romarb_slot #(.AW(SCR_AW)) u_scr (
        .clk     (clk),
        .rst     (rst),
        .clr     (downloading),
        .wr      (scr_wr),
        .addr    (scr_addr),
        .wr_addr (lat_word[SCR_AW-1:0]),
        .wr_data (data_read),
        .data    (scr_data),
        .ok      (scr_ok),
        .pending (scr_pend)
    );

    jtdd_romarb_slot #(.AW(OBJ_AW)) u_obj (
        .clk     (clk),
        .rst     (rst),
        .clr     (downloading),
        .wr      (obj_wr),
        .addr    (obj_addr),
        .wr_addr (lat_word),
        .wr_data (data_read),
        .data    (obj_data),
        .ok      (obj_ok),
        .pending (obj_pend)
    );

    // The char layer reads bytes; the low address bit picks the half-word.
    assign char_data = char_addr[0] ? char_word[15:8] : char_word[7:0];
    assign any_pend  = char_pend || scr_pend || obj_pend;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
`ifdef JTDD_ROMARB_FIXPRIO_EN
    // Objects first: their line-buffer fill during HBL has the tightest deadline.
    always_comb begin
        arb_slot = SLOT_CHAR;
        if (obj_pend)
            arb_slot = SLOT_OBJ;
        else if (char_pend)
            arb_slot = SLOT_CHAR;
        else if (scr_pend)
            arb_slot = SLOT_SCR;
    end
`else
    // rr_ptr names the first slot to consider; it moves past a slot only
    // once that slot's fetch has completed, so aborted fetches keep their turn.
    slot_t rr_ptr;

    // Round-robin pointer update on fetch completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rr_ptr <= SLOT_CHAR;
        else if (done)
            rr_ptr <= next_slot(sel_slot);
    end

    // Round-robin search starting at rr_ptr.
    always_comb begin
        arb_slot = SLOT_CHAR;
        case (rr_ptr)
            SLOT_SCR: begin
                if (scr_pend)       arb_slot = SLOT_SCR;
                else if (obj_pend)  arb_slot = SLOT_OBJ;
                else if (char_pend) arb_slot = SLOT_CHAR;
            end
            SLOT_OBJ: begin
                if (obj_pend)       arb_slot = SLOT_OBJ;
                else if (char_pend) arb_slot = SLOT_CHAR;
                else if (scr_pend)  arb_slot = SLOT_SCR;
            end
            default: begin
                if (char_pend)      arb_slot = SLOT_CHAR;
                else if (scr_pend)  arb_slot = SLOT_SCR;
                else if (obj_pend)  arb_slot = SLOT_OBJ;
            end
        endcase
    end
`endif

    // Word address and SDRAM base of the selected requester.
    always_comb begin
        arb_word = '0;
        arb_base = CHAR_OFFSET;
        case (arb_slot)
            SLOT_SCR: begin
                arb_word = {1'b0, scr_addr};
                arb_base = SCR_OFFSET;
            end
            SLOT_OBJ: begin
                arb_word = obj_addr;
                arb_base = OBJ_OFFSET;
            end
            default: begin
                arb_word = {4'b0000, char_addr[14:1]};
                arb_base = CHAR_OFFSET;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Fetch sequencer
    // ------------------------------------------------------------------
    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next state plus the start/done strobes; downloading always wins.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (!downloading && any_pend) begin
                    start     = 1'b1;
                    state_nxt = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (downloading) begin
                    state_nxt = IDLE;
                end else if (sdram_ack) begin
                    if (data_rdy) begin
                        done      = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = WAIT_DATA;
                    end
                end
            end
            WAIT_DATA: begin
                if (downloading) begin
                    state_nxt = IDLE;
                end else if (data_rdy) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request register: the request is live exactly while waiting for ack;
    // slot id, word address and SDRAM address are captured on start and
    // held until the next start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q      <= 1'b0;
            sdram_addr <= '0;
            sel_slot   <= SLOT_CHAR;
            lat_word   <= '0;
        end else begin
            req_q <= (state_nxt == WAIT_ACK);
            if (start) begin
                sel_slot   <= arb_slot;
                lat_word   <= arb_word;
                sdram_addr <= arb_base + {{(SDRAM_AW-OBJ_AW){1'b0}}, arb_word};
            end
        end
    end

    // A download takes the port away immediately, even mid-handshake.
    assign sdram_req = req_q && !downloading;

endmodule

// File: doc/jtdd_romarb.md
Name: jtdd_romarb

Overview:
- Arbitrates the single SDRAM read port between the three video ROM fetchers: char, scroll and object.
- Converts each requester's address-change traffic into SDRAM word requests.
- Caches one word per requester and drives that requester's data and ok back to the video layers.
- Sits between the video top level (char/scr/obj addr/data/ok buses) and the SDRAM controller.

Parameters:
- CHAR_OFFSET, 22'h00_0000, SDRAM word base of char ROM
- SCR_OFFSET, 22'h01_0000, SDRAM word base of scroll ROM
- OBJ_OFFSET, 22'h03_0000, SDRAM word base of object ROM

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- downloading  in  1  ROM download in progress; SDRAM port not available
- char_addr  in  15  char ROM byte address
- char_data  out  8  char byte
- char_ok  out  1  char_data valid for the current char_addr
- scr_addr  in  17  scroll ROM word address
- scr_data  out  16  scroll word
- scr_ok  out  1  scr_data valid for the current scr_addr
- obj_addr  in  18  object ROM word address
- obj_data  out  16  object word
- obj_ok  out  1  obj_data valid for the current obj_addr
- sdram_req  out  1  read request to the SDRAM controller
- sdram_addr  out  22  SDRAM word address
- sdram_ack  in  1  request accepted
- data_rdy  in  1  data_read valid, one-cycle pulse
- data_read  in  16  SDRAM read word

Behaviour:
- Reset values (async, rst=1):
  - State is IDLE; all slot valid bits are 0.
  - All *_ok and all *_data outputs are 0.
  - sdram_req=0, sdram_addr=0.
  - Round-robin pointer is CHAR.
- Per-slot cache (one each for char, scr, obj) holds: tag = word address of the last completed fetch, data = 16-bit word, valid bit.
- Char word address is char_addr[14:1]. char_data = char_addr[0] ? data[15:8] : data[7:0].
- *_ok = valid && (current word address == tag). This is combinational, so ok drops in the same cycle the address changes.
- A slot is pending when !ok.
- FSM states: IDLE, WAIT_ACK, WAIT_DATA.
- IDLE:
  - If any slot is pending and downloading=0, select one (see arbitration).
  - Latch the slot id and its word address.
  - Next cycle: sdram_addr = OFFSET + word address (zero-extended, 22-bit wrap), sdram_req=1, go to WAIT_ACK.
- WAIT_ACK:
  - Hold sdram_req=1 and sdram_addr stable until sdram_ack.
  - On ack: sdram_req=0, go to WAIT_DATA.
  - If ack and data_rdy arrive in the same cycle, complete the fetch and go straight to IDLE.
- WAIT_DATA:
  - On data_rdy: write data_read into the latched slot, set tag = latched address, valid=1, go to IDLE.
- Latency:
  - Address change to sdram_req rise: 1 cycle.
  - *_ok rises the cycle after data_rdy, provided the address is unchanged.
- Address change mid-fetch:
  - The fetched data is still stored against the latched tag.
  - ok stays 0 because of the tag mismatch; the slot is pending again at the next IDLE.
  - There is no abort and no duplicated request.
- Arbitration (default, round-robin):
  - Search starts at the slot after the last-served slot, order CHAR→SCR→OBJ→CHAR.
  - Pointer advances only when a fetch completes.
- downloading=1:
  - Valid bits clear on the next edge; the FSM is forced to IDLE.
  - sdram_req=0 in any state, including mid WAIT_ACK/WAIT_DATA.
  - A data_rdy arriving while downloading=1 is ignored.
- Only one outstanding SDRAM request at any time.

Optional Feature:
- Macro: JTDD_ROMARB_FIXPRIO_EN
- Defined: fixed priority OBJ > CHAR > SCR. Objects get priority because their HBL line-buffer fill is the tightest deadline. The round-robin pointer is removed.
- Undefined: round-robin as above.
- All other timing is identical in both builds.

Decomposition:
- Package jtdd_romarb_pkg holds:
  - slot enum: SLOT_CHAR=0, SLOT_SCR=1, SLOT_OBJ=2
  - FSM state enum: IDLE, WAIT_ACK, WAIT_DATA
  - constant SDRAM_AW=22
- Sub-module jtdd_romarb_slot (parameter AW = requester word-address width). It holds the tag/data/valid registers, the compare logic and ok/pending generation. It is instantiated three times; the top level keeps the FSM, arbitration and address mux.

Test Plan:
- Reset then scr_addr=17'h00123 → sdram_req=1 with sdram_addr=22'h010123. Ack, then data_rdy with data_read=16'hBEEF → next cycle scr_ok=1, scr_data=16'hBEEF.
- char_addr=15'h0005 with cached word 16'hA55A → char_data=8'hA5, char_ok=1. Change to 15'h0004 (same word) → char_data=8'h5A, no new sdram_req.
- All three slots pending at once (default build) → fetches in order CHAR, SCR, OBJ. With JTDD_ROMARB_FIXPRIO_EN → order OBJ, CHAR, SCR.
- obj_addr changes from 18'h00010 to 18'h00020 during WAIT_DATA → obj_ok stays 0 after data_rdy, and a second request for 22'h030020 is issued.
- downloading asserted during WAIT_ACK → sdram_req=0 next cycle, all *_ok=0. After deassertion, requests reissue for all slots.
- sdram_ack and data_rdy in the same cycle in WAIT_ACK → slot updated, FSM back in IDLE next cycle.
